aes_encrypt_core_multikey: RTL

Iterative AES encryption core, one round per clock, supporting AES-128/192/256 selected per block. Successor to the fixed 128-bit-key encrypt core. Adds valid/ready handshakes on input and output and a stallable round-key request port, so it can share a key-expansion unit or round-key RAM. Also adds abort and error reporting. It sits between the block-cipher mode controller upstream and the key-schedule unit that supplies round keys.

---
 rtl/aes_encrypt_core_multikey.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_encrypt_core_multikey.sv
// ---------------------------------------------------------------------------
// aes_encrypt_core_multikey
//
// Iterative AES encryption core (AES-128/192/256 selectable per block).
// One round is computed per consumed round key; round keys are pulled from
// an external key-schedule unit or RAM through a stallable request port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_valid/in_ready move a block in; out_valid/out_ready move
// a result out; rk_req/rk_valid move one round key in. The core never drops
// a ready/req it has raised until the matching transfer or an abort.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready    input block handshake
//   plain_text, key_len   input block and key size (0=128, 1=192, 2=256)
//   rk_req, rk_idx        round-key request and index (0..Nr)
//   rk_valid, rk_data     round-key response
//   abort                 drop the current block, return to IDLE
//   out_valid, out_ready  result handshake
//   cipher_text, out_err  result block; out_err flags an unsupported key_len
//   busy, round_num       FSM not idle; current round counter
// ---------------------------------------------------------------------------
module aes_encrypt_core_multikey #(
    parameter bit ALLOW_192 = 1'b1,
    parameter bit ALLOW_256 = 1'b1,
    parameter int RK_IDX_W  = 4     // must be >= 4 to hold indices up to 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plain_text,
    input  logic [1:0]          key_len,
    output logic                rk_req,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic                rk_valid,
    input  logic [127:0]        rk_data,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        cipher_text,
    output logic                out_err,
    output logic                busy,
    output logic [3:0]          round_num
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Forward S-box, byte x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_BITS = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // State byte n (column n/4, row n%4) sits at bits [127-8n -: 8].
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_BITS[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Row r is rotated left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) & 3) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   nr_q, nr_d;
    logic         err_q, err_d;

    logic [127:0] sr_data;   // ShiftRows(SubBytes(data)), final round
    logic [127:0] mc_data;   // plus MixColumns, middle rounds
    logic         key_ok;
    logic [3:0]   key_nr;

    assign sr_data = shift_rows(sub_bytes(data_q));
    assign mc_data = mix_columns(sr_data);

    always_comb begin
        key_ok = 1'b0;
        key_nr = 4'd10;
        case (key_len)
            2'd0: begin key_ok = 1'b1;      key_nr = 4'd10; end
            2'd1: begin key_ok = ALLOW_192; key_nr = 4'd12; end
            2'd2: begin key_ok = ALLOW_256; key_nr = 4'd14; end
            default: begin key_ok = 1'b0;   key_nr = 4'd10; end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            round_q <= '0;
            nr_q    <= 4'd10;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        round_d = round_q;
        nr_d    = nr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // abort outranks a pending accept
                if (!abort && in_valid) begin
                    nr_d    = key_nr;
                    round_d = 4'd0;
                    if (key_ok) begin
                        data_d  = plain_text;
                        err_d   = 1'b0;
                        state_d = ROUND;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ROUND: begin
                if (abort) begin
                    state_d = IDLE;
                    round_d = 4'd0;
                end else if (rk_valid) begin
                    if (round_q == 4'd0) begin
                        data_d = data_q ^ rk_data;
                    end else if (round_q < nr_q) begin
                        data_d = mc_data ^ rk_data;
                    end else begin
                        data_d = sr_data ^ rk_data;
                    end
                    // round_num saturates at Nr; it is cleared on the way back to IDLE
                    if (round_q == nr_q) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                    round_d = 4'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign rk_req      = (state_q == ROUND);
    assign rk_idx      = RK_IDX_W'(round_q);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign cipher_text = data_q;
    assign out_err     = err_q;
    assign round_num   = round_q;

endmodule
